// File: rtl/mempll_rst_seq.sv
// mempll_rst_seq: memory PLL reset/lock sequencer with lock qualification, timeout retry and fault reporting.
// Define MEMPLL_RST_SEQ_LOSS_RECOVER_EN to auto-recover on lock loss in RUN; otherwise lock loss parks in HALT.
module mempll_rst_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_req,
  output logic       pll_reset,
  output logic       mem_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt
);
`ifdef MEMPLL_RST_SEQ_LOSS_RECOVER_EN
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;
  localparam state_t LOSS_NEXT = RESET_PLL;
`else
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, HALT} state_t;
  localparam state_t LOSS_NEXT = HALT;
`endif
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] sync_q, sync_d;
  logic fault_q, fault_d;
  logic [7:0] retry_q, retry_d;
  logic lock_s, loss;
  assign lock_s = sync_q[1];
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    loss = 1'b0;
    sync_d = {sync_q[0], pll_lock};
    case (state_q)
      RESET_PLL: if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK:
        if (soft_req) state_d = RESET_PLL;
        else if (lock_s) state_d = STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = RESET_PLL;
          loss = 1'b1;
        end
      STABLE:
        if (soft_req) state_d = RESET_PLL;
        else if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = RUN;
          fault_d = 1'b0;
        end
      // a lock loss coinciding with soft_req is still counted
      RUN:
        if (!lock_s) begin
          loss = 1'b1;
          state_d = soft_req ? RESET_PLL : LOSS_NEXT;
        end else if (soft_req) state_d = RESET_PLL;
`ifndef MEMPLL_RST_SEQ_LOSS_RECOVER_EN
      HALT: if (soft_req) state_d = RESET_PLL;
`endif
      default: state_d = RESET_PLL;
    endcase
    if (loss) fault_d = 1'b1;
    retry_d = (loss && retry_q != 8'hff) ? retry_q + 8'd1 : retry_q;
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      sync_q  <= '0;
      fault_q <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      fault_q <= fault_d;
      retry_q <= retry_d;
    end
  end
  assign pll_reset = (state_q == RESET_PLL);
  assign mem_rst_n = (state_q == RUN);
  assign ready     = (state_q == RUN);
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_mempll_rst_seq.sv
// tb_mempll_rst_seq: directed self-checking bench for mempll_rst_seq (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32).
module tb_mempll_rst_seq;
  logic clk = 1'b0;
  logic rst_n, pll_lock, soft_req;
  logic pll_reset, mem_rst_n, ready, fault;
  logic [7:0] retry_cnt;
  int n_cmp = 0, n_err = 0, n;
  mempll_rst_seq #(.RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .CNT_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .soft_req(soft_req),
    .pll_reset(pll_reset), .mem_rst_n(mem_rst_n), .ready(ready), .fault(fault), .retry_cnt(retry_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pulse_len(output int c);
    c = 0;
    while (pll_reset && c < 200) begin
      c++;
      tick();
    end
  endtask
  task automatic ticks_to_run(output int c);
    c = 0;
    while (!mem_rst_n && c < 200) begin
      tick();
      c++;
    end
  endtask
  task automatic ticks_to_rst(output int c);
    c = 0;
    while (!pll_reset && c < 200) begin
      tick();
      c++;
    end
  endtask
  task automatic ticks_to_memoff(output int c);
    c = 0;
    while (mem_rst_n && c < 200) begin
      tick();
      c++;
    end
  endtask
  initial begin
    rst_n = 1'b0; pll_lock = 1'b0; soft_req = 1'b0;
    repeat (3) tick();
    check("rst_pll_reset", pll_reset, 1);
    check("rst_mem_rst_n", mem_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_cnt, 0);
    rst_n = 1'b1;
    pulse_len(n);
    check("first_pulse", n, 4);
    pll_lock = 1'b1;
    ticks_to_run(n);
    check("first_run_lat", n, 11);
    check("first_ready", ready, 1);
    check("first_fault", fault, 0);
    check("first_retry", retry_cnt, 0);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check("soft_pll_reset", pll_reset, 1);
    check("soft_mem_rst_n", mem_rst_n, 0);
    check("soft_retry", retry_cnt, 0);
    pll_lock = 1'b0;
    pulse_len(n);
    check("soft_pulse", n, 4);
    ticks_to_rst(n);
    check("timeout_lat", n, 32);
    check("timeout_fault", fault, 1);
    check("timeout_retry", retry_cnt, 1);
    pulse_len(n);
    check("retry_pulse", n, 4);
    pll_lock = 1'b1;
    ticks_to_run(n);
    check("after_to_run_lat", n, 11);
    check("after_to_fault", fault, 0);
    check("after_to_retry", retry_cnt, 1);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    pulse_len(n);
    repeat (3) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    pll_lock = 1'b1;
    ticks_to_run(n);
    check("glitch_run_lat", n, 11);
    check("glitch_retry", retry_cnt, 1);
    check("glitch_fault", fault, 0);
    pll_lock = 1'b0;
    ticks_to_memoff(n);
    check("loss_lat", n, 3);
    check("loss_retry", retry_cnt, 2);
    check("loss_fault", fault, 1);
`ifdef MEMPLL_RST_SEQ_LOSS_RECOVER_EN
    check("loss_recover", pll_reset, 1);
    pll_lock = 1'b1;
`else
    check("loss_halt", pll_reset, 0);
    repeat (5) tick();
    check("halt_mem_rst_n", mem_rst_n, 0);
    check("halt_pll_reset", pll_reset, 0);
    check("halt_fault", fault, 1);
    pll_lock = 1'b1;
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check("halt_soft", pll_reset, 1);
`endif
    pulse_len(n);
    check("loss_pulse", n, 4);
    ticks_to_run(n);
    check("loss_run_lat", n, 9);
    check("loss_run_fault", fault, 0);
    pll_lock = 1'b0;
    repeat (2) tick();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check("both_pll_reset", pll_reset, 1);
    check("both_retry", retry_cnt, 3);
    check("both_fault", fault, 1);
    repeat (251 * 36) tick();
    check("sat_254", retry_cnt, 254);
    repeat (36) tick();
    check("sat_255", retry_cnt, 255);
    repeat (48 * 36) tick();
    check("sat_hold", retry_cnt, 255);
    pll_lock = 1'b1;
    pulse_len(n);
    repeat (3) tick();
    check("stable_pll_reset", pll_reset, 0);
    check("stable_mem_rst_n", mem_rst_n, 0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_pll_reset", pll_reset, 1);
    check("mid_rst_mem_rst_n", mem_rst_n, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_fault", fault, 0);
    check("mid_rst_retry", retry_cnt, 0);
    rst_n = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
